popcount_accum: RTL and testbench

//  Downstream consumer of the 8-bit popcount stage: accepts one 4-bit per-byte

---
 rtl/popcount_accum.sv | 81 ++++++++
 tb/tb_popcount_accum.sv | 137 +++++++++++++
 2 files changed

// File: rtl/popcount_accum.sv
// popcount_accum: sums per-byte popcounts over a valid/ready frame and presents the frame total.
// Ports:
//   CLK, RESET (sync, active-high).
//   in_valid / in_ready / in_cnt / in_last: the input word stream.
//   out_valid / out_ready / out_total / out_words / out_ovf: the per-frame result, held until taken.
// Build option POPCOUNT_ACCUM_SAT_EN:
//   Saturating accumulators with an overflow flag on out_ovf.
//   Without it, the counters wrap and out_ovf is tied low.
module popcount_accum #(
  parameter int CNT_W  = 4,
  parameter int ACC_W  = 16,
  parameter int WCNT_W = 12
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CNT_W-1:0]  in_cnt,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_total,
  output logic [WCNT_W-1:0] out_words,
  output logic              out_ovf
);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t              state_q;
  logic [ACC_W-1:0]    acc_q, acc_d, total_q;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d, words_q;
  logic                in_acc;
  assign in_ready  = state_q == ACCUM;
  assign out_valid = state_q == HOLD;
  assign out_total = total_q;
  assign out_words = words_q;
  assign in_acc    = in_valid & in_ready;
`ifdef POPCOUNT_ACCUM_SAT_EN
  logic [ACC_W:0]  acc_sum;
  logic [WCNT_W:0] wcnt_sum;
  logic            ovf_q, ovf_d, out_ovf_q;
  // One extra carry bit per adder detects the add that would leave the range.
  assign acc_sum  = {1'b0, acc_q} + (ACC_W+1)'(in_cnt);
  assign wcnt_sum = {1'b0, wcnt_q} + (WCNT_W+1)'(1);
  assign acc_d    = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
  assign wcnt_d   = wcnt_sum[WCNT_W] ? '1 : wcnt_sum[WCNT_W-1:0];
  assign ovf_d    = ovf_q | acc_sum[ACC_W] | wcnt_sum[WCNT_W];
  assign out_ovf  = out_ovf_q;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ovf_q     <= 1'b0;
      out_ovf_q <= 1'b0;
    end else if (in_acc) begin
      ovf_q     <= in_last ? 1'b0 : ovf_d;
      out_ovf_q <= in_last ? ovf_d : out_ovf_q;
    end
  end
`else
  assign acc_d   = acc_q + ACC_W'(in_cnt);
  assign wcnt_d  = wcnt_q + WCNT_W'(1);
  assign out_ovf = 1'b0;
`endif
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      wcnt_q  <= '0;
      total_q <= '0;
      words_q <= '0;
    end else if (in_acc && in_last) begin
      total_q <= acc_d;
      words_q <= wcnt_d;
      acc_q   <= '0;
      wcnt_q  <= '0;
      state_q <= HOLD;
    end else if (in_acc) begin
      acc_q   <= acc_d;
      wcnt_q  <= wcnt_d;
    end else if (state_q == HOLD && out_ready) begin
      state_q <= ACCUM;
    end
  end
endmodule

// File: tb/tb_popcount_accum.sv
// tb_popcount_accum: checks two widths of popcount_accum against a frame-level reference model.
module tb_popcount_accum;
  logic CLK = 1'b0, RESET = 1'b1;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [3:0] in_cnt = '0;
  logic a_ready, a_valid, a_ovf, s_ready, s_valid, s_ovf;
  logic [15:0] a_total;
  logic [11:0] a_words;
  logic [3:0] s_total;
  logic [2:0] s_words;
  int passes = 0, checks = 0;
  bit m_hold = 0;
  int q[$];
  int r_sum = 0, r_n = 0;
  int stalls;
  bit lst;

  always #5 CLK = ~CLK;

  popcount_accum dut (.CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(a_ready),
    .in_cnt(in_cnt), .in_last(in_last), .out_valid(a_valid), .out_ready(out_ready),
    .out_total(a_total), .out_words(a_words), .out_ovf(a_ovf));

  popcount_accum #(.CNT_W(4), .ACC_W(4), .WCNT_W(3)) dut_s (.CLK(CLK), .RESET(RESET),
    .in_valid(in_valid), .in_ready(s_ready), .in_cnt(in_cnt), .in_last(in_last),
    .out_valid(s_valid), .out_ready(out_ready), .out_total(s_total), .out_words(s_words),
    .out_ovf(s_ovf));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
  endtask

  function automatic int fit(input int v, input int w);
    int mx = (1 << w) - 1;
`ifdef POPCOUNT_ACCUM_SAT_EN
    return v > mx ? mx : v;
`else
    return v & mx;
`endif
  endfunction

  function automatic int ovf(input int s, input int n, input int aw, input int ww);
`ifdef POPCOUNT_ACCUM_SAT_EN
    return int'(s > (1 << aw) - 1 || n > (1 << ww) - 1);
`else
    return 0;
`endif
  endfunction

  task automatic check_out();
    chk("out_valid", a_valid, m_hold);
    chk("out_valid_s", s_valid, m_hold);
    if (m_hold) begin
      chk("out_total", a_total, fit(r_sum, 16));
      chk("out_words", a_words, fit(r_n, 12));
      chk("out_ovf", a_ovf, ovf(r_sum, r_n, 16, 12));
      chk("out_total_s", s_total, fit(r_sum, 4));
      chk("out_words_s", s_words, fit(r_n, 3));
      chk("out_ovf_s", s_ovf, ovf(r_sum, r_n, 4, 3));
    end
  endtask

  task automatic cycle(input bit v, input int c, input bit l, input bit r);
    in_valid = v; in_cnt = 4'(c); in_last = l; out_ready = r;
    chk("in_ready", a_ready, !m_hold);
    chk("in_ready_s", s_ready, !m_hold);
    @(posedge CLK);
    if (!m_hold && v) begin
      q.push_back(c);
      if (l) begin
        r_sum = q.sum(); r_n = q.size(); q.delete(); m_hold = 1;
      end
    end else if (m_hold && r) m_hold = 0;
    #1;
    check_out();
  endtask

  task automatic do_reset();
    RESET = 1'b1; in_valid = 1'b1; in_cnt = 4'd5; in_last = 1'b1; out_ready = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0; m_hold = 0; q.delete();
    chk("rst_out_valid", a_valid, 0);
    chk("rst_in_ready", a_ready, 1);
    chk("rst_out_total", a_total, 0);
    chk("rst_out_words", a_words, 0);
    chk("rst_out_ovf", a_ovf, 0);
    chk("rst_out_valid_s", s_valid, 0);
  endtask

  initial begin
    do_reset();
    cycle(1, 3, 0, 1); cycle(1, 8, 0, 1); cycle(1, 0, 0, 1); cycle(1, 5, 1, 1);
    chk("t1_total", a_total, 16);
    chk("t1_words", a_words, 4);
    cycle(1, 9, 1, 1);
    cycle(0, 0, 0, 1);
    cycle(1, 3, 0, 0); cycle(1, 8, 0, 0); cycle(1, 0, 0, 0); cycle(1, 5, 1, 0);
    for (int i = 0; i < 3; i++) cycle(1, $urandom_range(0, 15), 1, 0);
    chk("t2_stable", a_total, 16);
    cycle(1, 2, 1, 1);
    cycle(1, 7, 1, 1);
    chk("t3_total", a_total, 7);
    chk("t3_words", a_words, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 6, 1, 1); cycle(1, 4, 0, 1); cycle(0, 9, 1, 1); cycle(1, 1, 1, 1);
    chk("t3_gap_total", a_total, 5);
    cycle(0, 0, 0, 1);
    cycle(1, 8, 0, 1); cycle(1, 8, 1, 1);
    cycle(0, 0, 0, 1);
    cycle(1, 2, 1, 1);
    chk("t4_next_total_s", s_total, 2);
    chk("t4_next_ovf_s", s_ovf, 0);
    cycle(0, 0, 0, 1);
    cycle(1, 4, 0, 1); cycle(1, 4, 0, 1);
    do_reset();
    cycle(1, 1, 1, 0);
    chk("t5_total", a_total, 1);
    chk("t5_words", a_words, 1);
    do_reset();
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      if (!a_ready) stalls++;
      lst = (q.size() == 2);
      cycle(1, $urandom_range(0, 8), lst, 1);
    end
    chk("t6_stalls", stalls, 5);
    for (int i = 0; i < 9; i++) cycle(1, 8, i == 8, $urandom_range(0, 1));
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0,
            $urandom_range(0, 9) == 0 ? $urandom_range(9, 15) : $urandom_range(0, 8),
            $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
